unidade_controle_multiciclo: RTL and testbench

Multicycle control FSM that replaces hand-sequenced datapath control. Fetches 32-bit RV64 words from the instruction memory, decodes LD/SD/ADD/SUB/ADDI, and drives the existing register bank, ULA and data memory control lines. It is parametrised in data width, register count and instruction address width, and adds a program counter, immediate generation, x0 protection and halt/illegal handling.

---
 rtl/riscv_ctrl_pkg.sv | 99 +++++++++
 rtl/unidade_controle_multiciclo_gerador_imediato.sv | 33 +++
 rtl/unidade_controle_multiciclo.sv | 218 +++++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle control unit: FSM state encoding,
// decoded-operation tags, immediate formats, ULA mux select codes, RV64
// opcode/funct constants and the instruction decode helpers.
// Optional feature macro: BRANCH_EN (adds BEQ/BNE to the decoder).
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_ILLEGAL,
        OP_HALT,
        OP_LD,
        OP_SD,
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_BEQ,
        OP_BNE
    } op_e;

    typedef enum logic [1:0] {
        FMT_I,
        FMT_S,
        FMT_B
    } imm_fmt_e;

    // ULA input mux codes: A = douta (rs2), B = doutb (rs1), C = constante
    localparam logic [1:0] SEL_B = 2'd0;
    localparam logic [1:0] SEL_A = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] INSTR_ZERO  = 32'h0000_0000;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    // Anything not explicitly recognised ends in HALT with illegal set;
    // the all-zero word and ECALL are the clean ways to stop the machine.
    function automatic op_e decode_op(input logic [31:0] ins);
        op_e op;
        op = OP_ILLEGAL;
        if (ins == INSTR_ZERO || ins == INSTR_ECALL) begin
            op = OP_HALT;
        end else begin
            case (ins[6:0])
                OPC_LOAD:  if (ins[14:12] == F3_DOUBLE) op = OP_LD;
                OPC_STORE: if (ins[14:12] == F3_DOUBLE) op = OP_SD;
                OPC_OP: begin
                    if (ins[14:12] == F3_ADD) begin
                        if (ins[31:25] == F7_ADD)      op = OP_ADD;
                        else if (ins[31:25] == F7_SUB) op = OP_SUB;
                    end
                end
                OPC_OPIMM: if (ins[14:12] == F3_ADD) op = OP_ADDI;
`ifdef BRANCH_EN
                OPC_BRANCH: begin
                    if (ins[14:12] == F3_BEQ)      op = OP_BEQ;
                    else if (ins[14:12] == F3_BNE) op = OP_BNE;
                end
`endif
                default: op = OP_ILLEGAL;
            endcase
        end
        return op;
    endfunction

    // Stores use the split S-immediate, branches the B-immediate, and
    // everything else (loads, ADDI) the plain I-immediate.
    function automatic imm_fmt_e imm_format(input op_e op);
        imm_fmt_e fmt;
        fmt = FMT_I;
        if (op == OP_SD)                        fmt = FMT_S;
        else if (op == OP_BEQ || op == OP_BNE)  fmt = FMT_B;
        return fmt;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_gerador_imediato.sv
// ---------------------------------------------------------------------------
// gerador_imediato
// Builds the sign-extended immediate for the datapath from the instruction
// fields that carry immediate bits.
// Ports:
//   i_instrHi  instr[31:20]
//   i_instrLo  instr[11:7]
//   i_fmt      immediate format (I, S or B)
//   o_imm      XLEN-bit sign-extended immediate
// ---------------------------------------------------------------------------
module gerador_imediato
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [11:0]     i_instrHi,
    input  logic [4:0]      i_instrLo,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    // B-immediate is a byte offset with an implicit zero LSB.
    always_comb begin
        o_imm = {{(XLEN-12){i_instrHi[11]}}, i_instrHi};
        case (i_fmt)
            FMT_S: o_imm = {{(XLEN-12){i_instrHi[11]}}, i_instrHi[11:5], i_instrLo};
            FMT_B: o_imm = {{(XLEN-13){i_instrHi[11]}}, i_instrHi[11], i_instrLo[0],
                            i_instrHi[10:5], i_instrLo[4:1], 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo
// Multicycle control FSM: fetches instructions, decodes LD/SD/ADD/SUB/ADDI
// and sequences register bank, ULA and data memory control lines.
// Optional feature macro: BRANCH_EN (BEQ/BNE support plus i_ula_zero input).
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start                 leave IDLE and run from the current PC
//   i_instr                 instruction memory data (valid cycle after o_endr)
//   i_ula_zero              ULA result is zero (BRANCH_EN only)
//   o_endr                  instruction address (PC, word index)
//   o_Ra / o_Rb / o_Rw      rs2 / rs1 / rd register addresses
//   o_WeR / o_WeM           register bank / data memory write enables
//   o_dinR_sel              register din: 0 ULA result, 1 memory data
//   o_constante             sign-extended immediate
//   o_soma_ou_subtrai       ULA enable, o_subtraindo selects subtraction
//   o_escolhe_entrada1/2    ULA input muxes (A=1, B=0, C=2)
//   o_busy / o_halted       running / stopped in HALT
//   o_illegal               sticky, halted on an unsupported encoding
// ---------------------------------------------------------------------------
module unidade_controle_multiciclo
    import riscv_ctrl_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          REG_AW   = 5,
    parameter int          PC_W     = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [31:0]       i_instr,
`ifdef BRANCH_EN
    input  logic              i_ula_zero,
`endif
    output logic [PC_W-1:0]   o_endr,
    output logic [REG_AW-1:0] o_Ra,
    output logic [REG_AW-1:0] o_Rb,
    output logic [REG_AW-1:0] o_Rw,
    output logic              o_WeR,
    output logic              o_WeM,
    output logic              o_dinR_sel,
    output logic [XLEN-1:0]   o_constante,
    output logic              o_soma_ou_subtrai,
    output logic              o_subtraindo,
    output logic [1:0]        o_escolhe_entrada1,
    output logic [1:0]        o_escolhe_entrada2,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_illegal
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_illegal;
    logic            r_weR;
    logic            r_weM;
    logic            r_dinSel;
    logic            r_soma;
    logic            r_sub;
    logic [1:0]      r_esc1;
    logic [1:0]      r_esc2;

    logic [31:0]     w_ir;
    op_e             w_op;
    logic            w_rdNonZero;
    logic [XLEN-1:0] w_imm;
    logic [PC_W-1:0] w_pcRetire;

    // During DECODE the instruction is still on the memory bus and IR is
    // only loaded at the end of the cycle, so fields are taken straight
    // from i_instr there and from IR afterwards.
    assign w_ir        = (r_state == ST_DECODE) ? i_instr : r_ir;
    assign w_op        = decode_op(w_ir);
    assign w_rdNonZero = |w_ir[11:7];

    gerador_imediato #(
        .XLEN(XLEN)
    ) u_gerador_imediato (
        .i_instrHi(w_ir[31:20]),
        .i_instrLo(w_ir[11:7]),
        .i_fmt    (imm_format(w_op)),
        .o_imm    (w_imm)
    );

`ifdef BRANCH_EN
    logic w_taken;

    // The B-immediate is a byte offset; PC counts words, hence bits [PC_W+1:2].
    assign w_taken    = (w_op == OP_BEQ && i_ula_zero) || (w_op == OP_BNE && !i_ula_zero);
    assign w_pcRetire = w_taken ? (r_pc + w_imm[PC_W+1:2]) : (r_pc + PC_W'(1));
`else
    assign w_pcRetire = r_pc + PC_W'(1);
`endif

    // Main sequencer. Control outputs are registered: they are loaded on the
    // transition into the state in which they must be visible and cleared on
    // retire, which keeps WeR/WeM confined to EXEC/MEM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= PC_W'(RESET_PC);
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_weR     <= 1'b0;
            r_weM     <= 1'b0;
            r_dinSel  <= 1'b0;
            r_soma    <= 1'b0;
            r_sub     <= 1'b0;
            r_esc1    <= SEL_B;
            r_esc2    <= SEL_B;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir <= i_instr;
                    case (w_op)
                        OP_HALT: r_state <= ST_HALT;
                        OP_ILLEGAL: begin
                            r_state   <= ST_HALT;
                            r_illegal <= 1'b1;
                        end
                        default: begin
                            r_state <= ST_EXEC;
                            r_soma  <= 1'b1;
                            case (w_op)
                                OP_ADD: begin
                                    r_esc1 <= SEL_A;
                                    r_esc2 <= SEL_B;
                                    r_weR  <= w_rdNonZero;
                                end
                                OP_SUB: begin
                                    r_esc1 <= SEL_B;
                                    r_esc2 <= SEL_A;
                                    r_sub  <= 1'b1;
                                    r_weR  <= w_rdNonZero;
                                end
                                OP_ADDI: begin
                                    r_esc1 <= SEL_B;
                                    r_esc2 <= SEL_C;
                                    r_weR  <= w_rdNonZero;
                                end
                                OP_SD: begin
                                    r_esc1 <= SEL_C;
                                    r_esc2 <= SEL_B;
                                    r_weM  <= 1'b1;
                                end
                                OP_LD: begin
                                    r_esc1 <= SEL_C;
                                    r_esc2 <= SEL_B;
                                end
                                OP_BEQ, OP_BNE: begin
                                    r_esc1 <= SEL_B;
                                    r_esc2 <= SEL_A;
                                    r_sub  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                ST_EXEC: begin
                    r_weM <= 1'b0;
                    if (w_op == OP_LD) begin
                        // Address mux stays put so memory data remains valid in MEM.
                        r_state  <= ST_MEM;
                        r_weR    <= w_rdNonZero;
                        r_dinSel <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_pcRetire;
                        r_weR   <= 1'b0;
                        r_soma  <= 1'b0;
                        r_sub   <= 1'b0;
                        r_esc1  <= SEL_B;
                        r_esc2  <= SEL_B;
                    end
                end
                ST_MEM: begin
                    r_state  <= ST_FETCH;
                    r_pc     <= r_pc + PC_W'(1);
                    r_weR    <= 1'b0;
                    r_dinSel <= 1'b0;
                    r_soma   <= 1'b0;
                    r_esc1   <= SEL_B;
                    r_esc2   <= SEL_B;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_endr             = r_pc;
    assign o_Ra               = REG_AW'(w_ir[24:20]);
    assign o_Rb               = REG_AW'(w_ir[19:15]);
    assign o_Rw               = REG_AW'(w_ir[11:7]);
    assign o_WeR              = r_weR;
    assign o_WeM              = r_weM;
    assign o_dinR_sel         = r_dinSel;
    assign o_constante        = w_imm;
    assign o_soma_ou_subtrai  = r_soma;
    assign o_subtraindo       = r_sub;
    assign o_escolhe_entrada1 = r_esc1;
    assign o_escolhe_entrada2 = r_esc2;
    assign o_busy             = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign o_halted           = (r_state == ST_HALT);
    assign o_illegal          = r_illegal;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_multiciclo
// Bench for the multicycle control unit. A small behavioural datapath
// (register bank, ULA, data memory, synchronous instruction memory) is
// driven by the DUT control lines so programs produce architectural results.
// Honours BRANCH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_unidade_controle_multiciclo;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rw;
      logic        weR;
      logic        weM;
      logic        sub;
      logic        isLoad;
      logic        checkImm;
      logic [1:0]  esc1;
      logic [1:0]  esc2;
      logic [63:0] imm;
   } vec_t;

   logic        clk;
   logic        rstN;
   logic        start;
   logic [31:0] instr;
   logic [4:0]  endr;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [4:0]  rw;
   logic        weR;
   logic        weM;
   logic        dinSel;
   logic [63:0] constante;
   logic        soma;
   logic        subtraindo;
   logic [1:0]  esc1;
   logic [1:0]  esc2;
   logic        busy;
   logic        halted;
   logic        illegal;

   logic [31:0] imem [32];
   logic [63:0] regs [32];
   logic [63:0] dmem [32];
   logic [63:0] douta;
   logic [63:0] doutb;
   logic [63:0] in1;
   logic [63:0] in2;
   logic [63:0] ulaOut;
   logic [63:0] dinR;

   int testsRun = 0;
   int testsFailed = 0;

   vec_t vecs [7];

`ifdef BRANCH_EN
   logic ulaZero;
   assign ulaZero = (ulaOut == 64'd0);
`endif

   unidade_controle_multiciclo #(
      .XLEN(64), .REG_AW(5), .PC_W(5), .RESET_PC(0)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rstN),
      .i_start           (start),
      .i_instr           (instr),
`ifdef BRANCH_EN
      .i_ula_zero        (ulaZero),
`endif
      .o_endr            (endr),
      .o_Ra              (ra),
      .o_Rb              (rb),
      .o_Rw              (rw),
      .o_WeR             (weR),
      .o_WeM             (weM),
      .o_dinR_sel        (dinSel),
      .o_constante       (constante),
      .o_soma_ou_subtrai (soma),
      .o_subtraindo      (subtraindo),
      .o_escolhe_entrada1(esc1),
      .o_escolhe_entrada2(esc2),
      .o_busy            (busy),
      .o_halted          (halted),
      .o_illegal         (illegal)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory: data appears the cycle after the address
   always @(posedge clk) instr <= imem[endr];

   // Datapath read side: register ports, ULA input muxes, ULA and load data
   always_comb begin
      douta = regs[ra];
      doutb = regs[rb];
      case (esc1)
         2'd1:    in1 = douta;
         2'd0:    in1 = doutb;
         2'd2:    in1 = constante;
         default: in1 = 64'd0;
      endcase
      case (esc2)
         2'd1:    in2 = douta;
         2'd0:    in2 = doutb;
         2'd2:    in2 = constante;
         default: in2 = 64'd0;
      endcase
      ulaOut = subtraindo ? (in1 - in2) : (in1 + in2);
      dinR   = dinSel ? dmem[ulaOut[4:0]] : ulaOut;
   end

   // Datapath write side; the register bank itself does not protect x0
   initial begin : datapathModel
      for (int i = 0; i < 32; i++) begin
         regs[i] = 64'd0;
         dmem[i] = 64'd0;
      end
      dmem[1] = 64'd7;
      dmem[2] = -64'sd3;
      forever begin
         @(posedge clk);
         if (weR) regs[rw] = dinR;
         if (weM) dmem[ulaOut[4:0]] = douta;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Walks one instruction from its FETCH cycle to the next FETCH cycle,
   // checking every intermediate cycle; called at a negedge inside FETCH.
   task automatic applyStimulus(input int idx, input vec_t v, input logic [4:0] expPc);
      string p;
      p = $sformatf("v%0d", idx);
      checkOutput({p, ".fetch.endr"}, 64'(endr), 64'(expPc));
      checkOutput({p, ".fetch.busy"}, 64'(busy), 64'd1);
      checkOutput({p, ".fetch.we"},   64'({weR, weM}), 64'd0);
      checkOutput({p, ".fetch.soma"}, 64'(soma), 64'd0);
      @(negedge clk);
      checkOutput({p, ".dec.Ra"},   64'(ra), 64'(v.ra));
      checkOutput({p, ".dec.Rb"},   64'(rb), 64'(v.rb));
      checkOutput({p, ".dec.Rw"},   64'(rw), 64'(v.rw));
      checkOutput({p, ".dec.we"},   64'({weR, weM}), 64'd0);
      checkOutput({p, ".dec.soma"}, 64'(soma), 64'd0);
      @(negedge clk);
      checkOutput({p, ".exec.WeR"},  64'(weR), 64'(v.weR));
      checkOutput({p, ".exec.WeM"},  64'(weM), 64'(v.weM));
      checkOutput({p, ".exec.esc1"}, 64'(esc1), 64'(v.esc1));
      checkOutput({p, ".exec.esc2"}, 64'(esc2), 64'(v.esc2));
      checkOutput({p, ".exec.sub"},  64'(subtraindo), 64'(v.sub));
      checkOutput({p, ".exec.soma"}, 64'(soma), 64'd1);
      checkOutput({p, ".exec.dsel"}, 64'(dinSel), 64'd0);
      checkOutput({p, ".exec.endr"}, 64'(endr), 64'(expPc));
      if (v.checkImm) checkOutput({p, ".exec.const"}, constante, v.imm);
      if (v.isLoad) begin
         @(negedge clk);
         checkOutput({p, ".mem.WeR"},  64'(weR), 64'(v.rw != 5'd0));
         checkOutput({p, ".mem.WeM"},  64'(weM), 64'd0);
         checkOutput({p, ".mem.dsel"}, 64'(dinSel), 64'd1);
         checkOutput({p, ".mem.esc1"}, 64'(esc1), 64'(v.esc1));
         checkOutput({p, ".mem.esc2"}, 64'(esc2), 64'(v.esc2));
         checkOutput({p, ".mem.soma"}, 64'(soma), 64'd1);
      end
      @(negedge clk);
   endtask

   // Holds reset for two cycles and checks the cleared state
   task automatic doReset(input string tag);
      rstN  = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput({tag, ".rst.we"},      64'({weR, weM}), 64'd0);
      checkOutput({tag, ".rst.endr"},    64'(endr), 64'd0);
      checkOutput({tag, ".rst.flags"},   64'({busy, halted, illegal}), 64'd0);
      checkOutput({tag, ".rst.ctrl"},    64'({soma, subtraindo, dinSel, esc1, esc2}), 64'd0);
      checkOutput({tag, ".rst.const"},   constante, 64'd0);
      rstN = 1'b1;
   endtask

   // Runs a single word at PC 0 and expects the machine to stop
   task automatic runHaltCase(input string tag, input logic [31:0] word, input logic expIllegal);
      int cycles;
      doReset(tag);
      imem[0] = word;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (!halted && cycles < 10) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, ".halted"},  64'(halted), 64'd1);
      checkOutput({tag, ".illegal"}, 64'(illegal), 64'(expIllegal));
      checkOutput({tag, ".endr"},    64'(endr), 64'd0);
      checkOutput({tag, ".we"},      64'({weR, weM}), 64'd0);
   endtask

`ifdef BRANCH_EN
   // NOPs up to PC 6, branch at PC 6, then checks the PC of the next fetch
   task automatic runBranch(input string tag, input logic [31:0] word, input logic [4:0] expPc);
      int cycles;
      doReset(tag);
      for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0013;
      imem[6] = word;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (endr != 5'd6 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, ".reach6"}, 64'(endr), 64'd6);
      @(negedge clk);
      @(negedge clk);
      checkOutput({tag, ".exec.esc"}, 64'({esc1, esc2, subtraindo}), 64'({2'd0, 2'd1, 1'b1}));
      checkOutput({tag, ".exec.we"},  64'({weR, weM}), 64'd0);
      @(negedge clk);
      checkOutput({tag, ".pc"},   64'(endr), 64'(expPc));
      checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
   endtask
`endif

   initial begin
      rstN  = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0000;

      //              instr         ra    rb    rw  weR  weM  sub  ld   chkI esc1  esc2  imm
      vecs[0] = '{32'h00103083, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 64'd1};
      vecs[1] = '{32'h00203103, 5'd2, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 64'd2};
      vecs[2] = '{32'h002081B3, 5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 64'd0};
      vecs[3] = '{32'h40208233, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 64'd0};
      vecs[4] = '{32'h80108293, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 64'hFFFF_FFFF_FFFF_F801};
      vecs[5] = '{32'h001032A3, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 64'd5};
      vecs[6] = '{32'h00308013, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 64'd3};
      for (int i = 0; i < 7; i++) imem[i] = vecs[i].instr;
      imem[7] = 32'hFFFF_FFFF;

      doReset("init");

      // start stays high for the whole program: it must have no effect while busy
      start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i], 5'(i));

      // Unsupported word at PC 7: FETCH, DECODE, then HALT with illegal set
      checkOutput("ill.fetch.endr", 64'(endr), 64'd7);
      @(negedge clk);
      @(negedge clk);
      checkOutput("ill.halted",  64'(halted), 64'd1);
      checkOutput("ill.illegal", 64'(illegal), 64'd1);
      checkOutput("ill.busy",    64'(busy), 64'd0);
      checkOutput("ill.we",      64'({weR, weM}), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("ill.stay.halted", 64'(halted), 64'd1);
      checkOutput("ill.stay.endr",   64'(endr), 64'd7);
      checkOutput("ill.stay.ill",    64'(illegal), 64'd1);
      start = 1'b0;

      checkOutput("arch.x0", regs[0], 64'd0);
      checkOutput("arch.x1", regs[1], 64'd7);
      checkOutput("arch.x2", regs[2], 64'hFFFF_FFFF_FFFF_FFFD);
      checkOutput("arch.x3", regs[3], 64'd4);
      checkOutput("arch.x4", regs[4], 64'd10);
      checkOutput("arch.x5", regs[5], 64'hFFFF_FFFF_FFFF_F808);
      checkOutput("arch.m5", dmem[5], 64'd7);

      runHaltCase("zero",  32'h0000_0000, 1'b0);
      runHaltCase("ecall", 32'h0000_0073, 1'b0);
      runHaltCase("f7bad", 32'h0220_81B3, 1'b1);
      runHaltCase("lw",    32'h0010_2083, 1'b1);
`ifdef BRANCH_EN
      runBranch("beq", 32'hFE10_8CE3, 5'd4);
      runBranch("bne", 32'hFE10_9CE3, 5'd7);
`else
      runHaltCase("beq", 32'hFE10_8CE3, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
